multi_ch_fifo: RTL and testbench
================================

// Module: multi_ch_fifo
// PURPOSE
//  NCH independent logical FIFOs sharing one statically partitioned storage array.
//  One enqueue port and one dequeue port, each with a channel select.
//  Successor to the single-channel FIFO family (same enq/deq/emp/ful/cnt semantics).
//  Used where several streams are buffered in one BRAM/LUTRAM block.
// PARAMETERS
//  FIFO_SIZE   4   log2 of entries per channel (16)
//  FIFO_WIDTH  32  data width in bits
//  CH_LOG      2   log2 of channel count; NCH = 2**CH_LOG (4)
// PORTS
//  CLK      in   1                        clock; all logic on posedge
//  RST      in   1                        reset, synchronous, active-high
//  ENQ      in   1                        enqueue request
//  ENQ_CH   in   CH_LOG                   enqueue channel
//  DIN      in   FIFO_WIDTH               enqueue data
//  DEQ      in   1                        dequeue request
//  DEQ_CH   in   CH_LOG                   dequeue channel
//  DOT      out  FIFO_WIDTH               dequeued data (registered)
//  DOT_VLD  out  1                        DOT updated this cycle
//  EMP      out  NCH                      per-channel empty
//  FUL      out  NCH                      per-channel full
//  CNT      out  NCH*(FIFO_SIZE+1)        per-channel count; ch i at [i*(FIFO_SIZE+1) +: FIFO_SIZE+1]
//  ERR      out  2                        only with MCF_ERR_CHK_EN; [0] overflow, [1] underflow
// BEHAVIOUR
//  - Storage: NCH*2**FIFO_SIZE words; address {ch, ptr}; no reset on storage.
//  - Per channel: head ptr, tail ptr (FIFO_SIZE bits, wrap mod 2**FIFO_SIZE), count (FIFO_SIZE+1 bits).
//  - EMP[i] = (cnt_i == 0); FUL[i] = (cnt_i == 2**FIFO_SIZE); combinational from registered counts.
//  - Enq accepted iff ENQ && !FUL[ENQ_CH]: mem[{ENQ_CH,tail}] <= DIN; tail++; cnt++.
//  - Deq accepted iff DEQ && !EMP[DEQ_CH]: DOT <= mem[{DEQ_CH,head}]; head++; cnt--.
//  - Latency: DOT/DOT_VLD valid 1 cycle after accepted deq; DOT_VLD is a 1-cycle pulse.
//    DOT holds its last value when no deq is accepted.
//  - Enq->deq latency: a word enqueued at cycle t is dequeueable from cycle t+1.
//  - Flags are judged on state before the edge:
//    enq to full channel dropped even if the same channel is dequeued that cycle;
//    deq from empty channel ignored even if the same channel is enqueued that cycle
//    (the enq is still accepted).
//  - Same-channel enq+deq both accepted: cnt unchanged, both pointers advance.
//  - Different-channel enq+deq: independent; each channel updates separately.
//  - Rejected requests change no state.
//  - Reset (at any time, including mid-operation):
//    all ptrs/cnt = 0, EMP = all 1, FUL = all 0, CNT = 0, DOT = 0, DOT_VLD = 0, ERR = 0.
//    Data held before reset is discarded.
// CONFIGURATION
//  MCF_ERR_CHK_EN defined:
//    ERR port present.
//    ERR[0] set sticky on ENQ to a full channel; ERR[1] set sticky on DEQ from an empty channel.
//    Cleared only by RST; set the cycle after the offending request.
//  MCF_ERR_CHK_EN undefined: no ERR port and no checking logic; illegal requests silently dropped.
// TESTING
//  1 Reset, then idle -> EMP=4'b1111, FUL=0, CNT=0, DOT_VLD=0.
//  2 ENQ ch1 DIN=1..16, then DEQ ch1 x16 -> DOT=1..16 in order, one per cycle;
//    FUL[1]=1 after 16th enq; EMP[1]=1 after last deq.
//  3 Interleave ch0 A0..A3 and ch3 B0..B3; deq ch3 then ch0 -> B0..B3 then A0..A3;
//    no cross-channel mixing.
//  4 Ch2 full, ENQ+DEQ ch2 same cycle -> enq dropped, CNT ch2=15, ERR[0]=1 (with macro).
//    Ch2 holding 3, ENQ+DEQ ch2 -> CNT stays 3.
//  5 DEQ empty ch0 with same-cycle ENQ ch0 DIN=0x55 -> DOT_VLD=0, CNT ch0=1, ERR[1]=1 (with macro);
//    next DEQ returns 0x55.
//  6 Fill ch0 with 10 words, pulse RST mid-stream -> all counts 0, EMP all 1;
//    push 20 words through ch0 afterwards -> correct order across pointer wrap.

Source files
------------

// File: rtl/multi_ch_fifo.sv
// Multi-channel FIFO: NCH logical FIFOs statically partitioned in one storage array.
// Optional sticky overflow/underflow flags on ERR when MCF_ERR_CHK_EN is defined.
module multi_ch_fifo #(
    parameter int FIFO_SIZE  = 4,
    parameter int FIFO_WIDTH = 32,
    parameter int CH_LOG     = 2
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      ENQ,
    input  logic [CH_LOG-1:0]                         ENQ_CH,
    input  logic [FIFO_WIDTH-1:0]                     DIN,
    input  logic                                      DEQ,
    input  logic [CH_LOG-1:0]                         DEQ_CH,
    output logic [FIFO_WIDTH-1:0]                     DOT,
    output logic                                      DOT_VLD,
    output logic [(2**CH_LOG)-1:0]                    EMP,
    output logic [(2**CH_LOG)-1:0]                    FUL,
    output logic [(2**CH_LOG)*(FIFO_SIZE+1)-1:0]      CNT
`ifdef MCF_ERR_CHK_EN
    ,
    output logic [1:0]                                ERR
`endif
);

    localparam int NCH   = 2**CH_LOG;
    localparam int DEPTH = 2**FIFO_SIZE;

    logic [FIFO_WIDTH-1:0] mem [NCH*DEPTH];
    logic [FIFO_SIZE-1:0]  head [NCH];
    logic [FIFO_SIZE-1:0]  tail [NCH];
    logic [FIFO_SIZE:0]    cnt  [NCH];

    logic           enq_ok, deq_ok;
    logic [NCH-1:0] enq_hit, deq_hit;

    // Count never exceeds DEPTH, so its MSB alone marks a full channel.
    always_comb begin
        EMP     = '0;
        FUL     = '0;
        CNT     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            EMP[i] = (cnt[i] == '0);
            FUL[i] = cnt[i][FIFO_SIZE];
            CNT[i*(FIFO_SIZE+1) +: (FIFO_SIZE+1)] = cnt[i];
        end
    end

    always_comb begin
        enq_ok  = ENQ && !FUL[ENQ_CH];
        deq_ok  = DEQ && !EMP[DEQ_CH];
        enq_hit = '0;
        deq_hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            enq_hit[i] = enq_ok && (ENQ_CH == CH_LOG'(i));
            deq_hit[i] = deq_ok && (DEQ_CH == CH_LOG'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (enq_ok)
            mem[{ENQ_CH, tail[ENQ_CH]}] <= DIN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (enq_hit[i])
                    tail[i] <= tail[i] + 1'b1;
                if (deq_hit[i])
                    head[i] <= head[i] + 1'b1;
                if (enq_hit[i] && !deq_hit[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!enq_hit[i] && deq_hit[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DOT     <= '0;
            DOT_VLD <= 1'b0;
        end else begin
            DOT_VLD <= deq_ok;
            if (deq_ok)
                DOT <= mem[{DEQ_CH, head[DEQ_CH]}];
        end
    end

`ifdef MCF_ERR_CHK_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= '0;
        end else begin
            if (ENQ && FUL[ENQ_CH])
                ERR[0] <= 1'b1;
            if (DEQ && EMP[DEQ_CH])
                ERR[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_ch_fifo.sv
// Bench for multi_ch_fifo: per-channel queue model checked every cycle plus directed literal checks.
// Follows MCF_ERR_CHK_EN to connect and check ERR when the feature is built in.
module tb_multi_ch_fifo;

    localparam int NCH = 4;
    localparam int D   = 16;
    localparam int CW  = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ENQ = 1'b0;
    logic [1:0]  ENQ_CH = '0;
    logic [31:0] DIN = '0;
    logic        DEQ = 1'b0;
    logic [1:0]  DEQ_CH = '0;
    logic [31:0] DOT;
    logic        DOT_VLD;
    logic [3:0]  EMP, FUL;
    logic [19:0] CNT;
`ifdef MCF_ERR_CHK_EN
    logic [1:0]  ERR;
`endif

    multi_ch_fifo #(.FIFO_SIZE(4), .FIFO_WIDTH(32), .CH_LOG(2)) dut (
        .CLK(CLK), .RST(RST),
        .ENQ(ENQ), .ENQ_CH(ENQ_CH), .DIN(DIN),
        .DEQ(DEQ), .DEQ_CH(DEQ_CH),
        .DOT(DOT), .DOT_VLD(DOT_VLD),
        .EMP(EMP), .FUL(FUL), .CNT(CNT)
`ifdef MCF_ERR_CHK_EN
        , .ERR(ERR)
`endif
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one queue per channel; acceptance judged on pre-edge occupancy.
    logic [31:0] q [NCH][$];
    logic [31:0] m_dot;
    logic        m_vld;
    logic [1:0]  m_err;
    logic        m_enq_ok, m_deq_ok;
    bit          checking = 0;

    always @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++) q[c].delete();
            m_dot = '0;
            m_vld = 1'b0;
            m_err = '0;
        end else begin
            m_enq_ok = ENQ && (q[ENQ_CH].size() < D);
            m_deq_ok = DEQ && (q[DEQ_CH].size() > 0);
            if (ENQ && !m_enq_ok) m_err[0] = 1'b1;
            if (DEQ && !m_deq_ok) m_err[1] = 1'b1;
            m_vld = m_deq_ok;
            if (m_deq_ok) m_dot = q[DEQ_CH].pop_front();
            if (m_enq_ok) q[ENQ_CH].push_back(DIN);
        end
    end

    always @(posedge CLK) begin
        #1;
        if (checking) begin
            for (int c = 0; c < NCH; c++) begin
                chk("EMP", 64'(EMP[c]), 64'(q[c].size() == 0));
                chk("FUL", 64'(FUL[c]), 64'(q[c].size() == D));
                chk("CNT", 64'(CNT[c*CW +: CW]), 64'(q[c].size()));
            end
            chk("DOT_VLD", 64'(DOT_VLD), 64'(m_vld));
            chk("DOT", 64'(DOT), 64'(m_dot));
`ifdef MCF_ERR_CHK_EN
            chk("ERR", 64'(ERR), 64'(m_err));
`endif
        end
    end

    task automatic cyc(input logic e, input logic [1:0] ec, input logic [31:0] d,
                       input logic dq, input logic [1:0] dc);
        ENQ = e; ENQ_CH = ec; DIN = d; DEQ = dq; DEQ_CH = dc;
        @(posedge CLK); #2;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(0, 0, 0, 0, 0);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        @(posedge CLK); #2;
        checking = 1;
        do_reset();

        // 1: reset state
        cyc(0, 0, 0, 0, 0);
        chk("t1_emp", 64'(EMP), 64'hF);
        chk("t1_ful", 64'(FUL), 64'h0);
        chk("t1_cnt", 64'(CNT), 64'h0);
        chk("t1_vld", 64'(DOT_VLD), 64'h0);

        // 2: fill and drain channel 1
        for (int k = 1; k <= 16; k++) cyc(1, 1, 32'(k), 0, 0);
        chk("t2_ful", 64'(FUL[1]), 64'h1);
        chk("t2_cnt", 64'(CNT[1*CW +: CW]), 64'd16);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 0, 1, 1);
            chk("t2_dot", 64'(DOT), 64'(k));
            chk("t2_vld", 64'(DOT_VLD), 64'h1);
        end
        chk("t2_emp", 64'(EMP[1]), 64'h1);

        // 3: interleaved channels stay separate
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 32'hA0 + 32'(k), 0, 0);
            cyc(1, 3, 32'hB0 + 32'(k), 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, 3);
            chk("t3_dot_b", 64'(DOT), 64'(32'hB0 + 32'(k)));
        end
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, 0);
            chk("t3_dot_a", 64'(DOT), 64'(32'hA0 + 32'(k)));
        end

        // 4: enq to full channel dropped even with same-cycle deq
        for (int k = 0; k < 16; k++) cyc(1, 2, 32'hC00 + 32'(k), 0, 0);
        cyc(1, 2, 32'hDEAD, 1, 2);
        chk("t4_cnt15", 64'(CNT[2*CW +: CW]), 64'd15);
        chk("t4_dot", 64'(DOT), 64'h0C00);
`ifdef MCF_ERR_CHK_EN
        chk("t4_err0", 64'(ERR[0]), 64'h1);
`endif
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 2);
        chk("t4_cnt3", 64'(CNT[2*CW +: CW]), 64'd3);
        cyc(1, 2, 32'hBEEF, 1, 2);
        chk("t4_cnt3_hold", 64'(CNT[2*CW +: CW]), 64'd3);
        chk("t4_dot2", 64'(DOT), 64'h0C0D);

        // 5: deq from empty ignored, same-cycle enq kept
        cyc(1, 0, 32'h55, 1, 0);
        chk("t5_vld", 64'(DOT_VLD), 64'h0);
        chk("t5_cnt", 64'(CNT[0 +: CW]), 64'd1);
`ifdef MCF_ERR_CHK_EN
        chk("t5_err1", 64'(ERR[1]), 64'h1);
`endif
        cyc(0, 0, 0, 1, 0);
        chk("t5_dot", 64'(DOT), 64'h55);
        chk("t5_vld2", 64'(DOT_VLD), 64'h1);

        // 6: mid-stream reset, then traffic across pointer wrap
        for (int k = 0; k < 10; k++) cyc(1, 0, 32'h100 + 32'(k), 0, 0);
        RST = 1'b1;
        cyc(1, 0, 32'h999, 1, 2);
        RST = 1'b0;
        chk("t6_cnt", 64'(CNT), 64'h0);
        chk("t6_emp", 64'(EMP), 64'hF);
        chk("t6_dot", 64'(DOT), 64'h0);
        chk("t6_vld", 64'(DOT_VLD), 64'h0);
`ifdef MCF_ERR_CHK_EN
        chk("t6_err", 64'(ERR), 64'h0);
`endif
        cyc(1, 0, 32'h200, 0, 0);
        for (int k = 1; k < 20; k++) begin
            cyc(1, 0, 32'h200 + 32'(k), 1, 0);
            chk("t6_wrap", 64'(DOT), 64'(32'h200 + 32'(k - 1)));
        end
        cyc(0, 0, 0, 1, 0);
        chk("t6_last", 64'(DOT), 64'h213);
        cyc(0, 0, 0, 0, 0);
        chk("t6_emp_end", 64'(EMP), 64'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
